// File: rtl/scv_cart_pkg.sv
// Shared types and helpers for the cartridge ROM loader.
package scv_cart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HI   = 3'd2,
        ST_FILL = 3'd3,
        ST_DONE = 3'd4
    } cart_loader_state_t;

    localparam int         ROM_AW_DEF    = 17;
    localparam logic [7:0] FILL_BYTE_DEF = 8'hFF;

    // Round an image size up to the enclosing power of two, minus one; sizes 0 and 1 map to 0.
    function automatic logic [31:0] size_to_mask(input logic [31:0] size);
        logic [31:0] m;
        if (size <= 32'd1) begin
            m = 32'd0;
        end else begin
            m = size - 32'd1;
            m = m | (m >> 1);
            m = m | (m >> 2);
            m = m | (m >> 4);
            m = m | (m >> 8);
            m = m | (m >> 16);
        end
        return m;
    endfunction

endpackage

// File: rtl/cart_loader.sv
// Converts the 16-bit host download stream into byte-wide ROM init writes, pads the
// unused ROM space with FILL_BYTE, and publishes the image size, mirror mask and ready flag.
module cart_loader
    import scv_cart_pkg::*;
#(
    parameter int         ROM_AW    = ROM_AW_DEF,
    parameter int         IOCTL_AW  = 25,
    parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                IOCTL_DOWNLOAD,
    input  logic                IOCTL_WR,
    input  logic [IOCTL_AW-1:0] IOCTL_ADDR,
    input  logic [15:0]         IOCTL_DATA,
    output logic                IOCTL_WAIT,
    output logic [ROM_AW-1:0]   INIT_ADDR,
    output logic [7:0]          INIT_DATA,
    output logic                INIT_VALID,
    output logic [ROM_AW:0]     CART_SIZE,
    output logic [ROM_AW-1:0]   ADDR_MASK,
    output logic                OVERFLOW,
    output logic                CART_READY
);

    localparam logic [ROM_AW:0] ROM_DEPTH = {1'b1, {ROM_AW{1'b0}}};

    cart_loader_state_t  state_q;
    logic                dl_prev_q;
    logic [IOCTL_AW-1:0] word_addr_q;
    logic [7:0]          hi_byte_q;
    logic [ROM_AW:0]     fill_cnt_q;
    logic                wait_q;
    logic [ROM_AW-1:0]   init_addr_q;
    logic [7:0]          init_data_q;
    logic                init_valid_q;
    logic [ROM_AW:0]     cart_size_q;
    logic [ROM_AW-1:0]   addr_mask_q;
    logic                overflow_q;
    logic                ready_q;

    logic                dl_rise_d;
    logic [IOCTL_AW-1:0] hi_addr_d;
    logic                lo_in_range_d;
    logic                hi_in_range_d;
    logic [ROM_AW:0]     lo_end_d;
    logic [ROM_AW:0]     hi_end_d;

    // Edge detect, byte addresses, range checks and candidate image ends for both halves of a word.
    always_comb begin
        dl_rise_d     = IOCTL_DOWNLOAD & ~dl_prev_q;
        hi_addr_d     = word_addr_q + {{(IOCTL_AW-1){1'b0}}, 1'b1};
        lo_in_range_d = (IOCTL_ADDR[IOCTL_AW-1:ROM_AW] == '0);
        hi_in_range_d = (hi_addr_d[IOCTL_AW-1:ROM_AW] == '0);
        lo_end_d      = {1'b0, IOCTL_ADDR[ROM_AW-1:0]} + {{ROM_AW{1'b0}}, 1'b1};
        hi_end_d      = {1'b0, hi_addr_d[ROM_AW-1:0]} + {{ROM_AW{1'b0}}, 1'b1};
    end

    // Loader FSM with all outputs registered.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            dl_prev_q    <= 1'b0;
            word_addr_q  <= '0;
            hi_byte_q    <= 8'h00;
            fill_cnt_q   <= '0;
            wait_q       <= 1'b0;
            init_addr_q  <= '0;
            init_data_q  <= 8'h00;
            init_valid_q <= 1'b0;
            cart_size_q  <= '0;
            addr_mask_q  <= '0;
            overflow_q   <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            dl_prev_q <= IOCTL_DOWNLOAD;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    init_valid_q <= 1'b0;
                    wait_q       <= 1'b0;
                    if (dl_rise_d) begin
                        cart_size_q <= '0;
                        overflow_q  <= 1'b0;
                        ready_q     <= 1'b0;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (IOCTL_WR) begin
                        word_addr_q  <= IOCTL_ADDR;
                        hi_byte_q    <= IOCTL_DATA[15:8];
                        init_addr_q  <= IOCTL_ADDR[ROM_AW-1:0];
                        init_data_q  <= IOCTL_DATA[7:0];
                        init_valid_q <= lo_in_range_d;
                        wait_q       <= 1'b1;
                        if (!lo_in_range_d) begin
                            overflow_q <= 1'b1;
                        end else if (lo_end_d > cart_size_q) begin
                            cart_size_q <= lo_end_d;
                        end
                        state_q <= ST_HI;
                    end else if (!IOCTL_DOWNLOAD) begin
                        init_valid_q <= 1'b0;
                        addr_mask_q  <= ROM_AW'(size_to_mask(32'(cart_size_q)));
                        if (cart_size_q == ROM_DEPTH) begin
                            ready_q <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            fill_cnt_q <= cart_size_q;
                            state_q    <= ST_FILL;
                        end
                    end else begin
                        init_valid_q <= 1'b0;
                    end
                end
                ST_HI: begin
                    init_addr_q  <= hi_addr_d[ROM_AW-1:0];
                    init_data_q  <= hi_byte_q;
                    init_valid_q <= hi_in_range_d;
                    wait_q       <= 1'b0;
                    if (!hi_in_range_d) begin
                        overflow_q <= 1'b1;
                    end else if (hi_end_d > cart_size_q) begin
                        cart_size_q <= hi_end_d;
                    end
                    state_q <= ST_LOAD;
                end
                ST_FILL: begin
                    wait_q <= 1'b0;
                    // A new download supersedes the image being padded.
                    if (dl_rise_d) begin
                        init_valid_q <= 1'b0;
                        cart_size_q  <= '0;
                        overflow_q   <= 1'b0;
                        ready_q      <= 1'b0;
                        state_q      <= ST_LOAD;
                    end else if (fill_cnt_q == ROM_DEPTH) begin
                        init_valid_q <= 1'b0;
                        ready_q      <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        init_valid_q <= 1'b1;
                        init_addr_q  <= fill_cnt_q[ROM_AW-1:0];
                        init_data_q  <= FILL_BYTE;
                        fill_cnt_q   <= fill_cnt_q + {{ROM_AW{1'b0}}, 1'b1};
                    end
                end
                default: begin
                    init_valid_q <= 1'b0;
                    wait_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign IOCTL_WAIT = wait_q;
    assign INIT_ADDR  = init_addr_q;
    assign INIT_DATA  = init_data_q;
    assign INIT_VALID = init_valid_q;
    assign CART_SIZE  = cart_size_q;
    assign ADDR_MASK  = addr_mask_q;
    assign OVERFLOW   = overflow_q;
    assign CART_READY = ready_q;

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader using a 256-byte ROM so full fills stay short.
module tb_cart_loader;

    localparam int AW    = 8;
    localparam int IAW   = 25;
    localparam int DEPTH = 1 << AW;

    logic           clk = 1'b0;
    logic           rst;
    logic           dl;
    logic           wr;
    logic [IAW-1:0] io_addr;
    logic [15:0]    io_data;
    logic           io_wait;
    logic [AW-1:0]  init_addr;
    logic [7:0]     init_data;
    logic           init_valid;
    logic [AW:0]    cart_size;
    logic [AW-1:0]  addr_mask;
    logic           overflow;
    logic           cart_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cart_loader #(
        .ROM_AW   (AW),
        .IOCTL_AW (IAW),
        .FILL_BYTE(8'hFF)
    ) dut (
        .CLK           (clk),
        .RESET         (rst),
        .IOCTL_DOWNLOAD(dl),
        .IOCTL_WR      (wr),
        .IOCTL_ADDR    (io_addr),
        .IOCTL_DATA    (io_data),
        .IOCTL_WAIT    (io_wait),
        .INIT_ADDR     (init_addr),
        .INIT_DATA     (init_data),
        .INIT_VALID    (init_valid),
        .CART_SIZE     (cart_size),
        .ADDR_MASK     (addr_mask),
        .OVERFLOW      (overflow),
        .CART_READY    (cart_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, 32'({io_wait, init_valid, overflow, cart_ready}), 32'd0);
        check({tag, "_wr"}, 32'({init_addr, init_data}), 32'd0);
        check({tag, "_sz"}, 32'({cart_size, addr_mask}), 32'd0);
    endtask

    task automatic dl_start();
        dl = 1'b1;
        @(negedge clk);
        check("start_flags", 32'({cart_ready, overflow, init_valid}), 32'd0);
        check("start_size", 32'(cart_size), 32'd0);
    endtask

    task automatic send_word(input int a, input logic [15:0] d);
        logic lo_ok;
        logic hi_ok;
        lo_ok   = (a < DEPTH);
        hi_ok   = (a + 1 < DEPTH);
        wr      = 1'b1;
        io_addr = IAW'(a);
        io_data = d;
        @(negedge clk);
        wr = 1'b0;
        check("wait_lo", 32'(io_wait), 32'd1);
        check("valid_lo", 32'(init_valid), 32'(lo_ok));
        if (lo_ok) check("byte_lo", 32'({init_addr, init_data}), 32'({AW'(a), d[7:0]}));
        @(negedge clk);
        check("wait_hi", 32'(io_wait), 32'd0);
        check("valid_hi", 32'(init_valid), 32'(hi_ok));
        if (hi_ok) check("byte_hi", 32'({init_addr, init_data}), 32'({AW'(a + 1), d[15:8]}));
    endtask

    task automatic load_image(input int nbytes, input int seed);
        for (int a = 0; a < nbytes; a += 2) begin
            send_word(a, 16'((a * 16'h0103) ^ seed));
        end
    endtask

    task automatic dl_end(input int exp_size, input int exp_mask);
        dl = 1'b0;
        @(negedge clk);
        check("end_size", 32'(cart_size), 32'(exp_size));
        check("end_mask", 32'(addr_mask), 32'(exp_mask));
        check("end_valid", 32'(init_valid), 32'd0);
        check("end_ready", 32'(cart_ready), (exp_size == DEPTH) ? 32'd1 : 32'd0);
    endtask

    task automatic fill_expect(input int start);
        for (int a = start; a < DEPTH; a++) begin
            @(negedge clk);
            check("fill_write", 32'({init_valid, init_addr, init_data}), 32'({1'b1, AW'(a), 8'hFF}));
        end
        @(negedge clk);
        check("done_ready", 32'({cart_ready, init_valid}), 32'b10);
    endtask

    initial begin
        rst     = 1'b1;
        dl      = 1'b0;
        wr      = 1'b0;
        io_addr = '0;
        io_data = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Four-word image, then pad to the top of the ROM.
        dl_start();
        send_word(0, 16'h2211);
        send_word(2, 16'h4433);
        send_word(4, 16'h6655);
        send_word(6, 16'h8877);
        check("size8", 32'(cart_size), 32'd8);
        dl_end(8, 7);
        fill_expect(8);
        repeat (3) @(negedge clk);
        check("done_hold", 32'({cart_ready, init_valid, cart_size}), 32'({1'b1, 1'b0, 9'd8}));
        wr = 1'b1;
        io_addr = '0;
        @(negedge clk);
        wr = 1'b0;
        check("wr_ignored", 32'({init_valid, io_wait}), 32'd0);

        // Power-of-two and non-power-of-two image sizes.
        dl_start();
        load_image(8'h80, 16'h5A3C);
        dl_end(9'h80, 8'h7F);
        fill_expect(8'h80);
        dl_start();
        load_image(8'h50, 16'h1E0F);
        dl_end(9'h50, 8'h7F);
        fill_expect(8'h50);

        // Full image: no padding, ready right after the download ends.
        dl_start();
        load_image(DEPTH, 16'h0F0F);
        dl_end(9'h100, 8'hFF);

        // Out-of-range word is dropped and flagged; in-range top word sets the full size.
        dl_start();
        send_word(9'h100, 16'hDEAD);
        check("ovf_set", 32'({overflow, cart_size}), 32'({1'b1, 9'd0}));
        send_word(8'hFE, 16'hCAFE);
        dl_end(9'h100, 8'hFF);
        check("ovf_held", 32'(overflow), 32'd1);

        // Out-of-order words keep the larger size; new download aborts the fill.
        dl_start();
        send_word(8'h10, 16'hA1A0);
        send_word(8'h00, 16'hB1B0);
        check("size_no_shrink", 32'(cart_size), 32'h12);
        dl_end(8'h12, 8'h1F);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("partial_fill", 32'({init_valid, init_addr, init_data}), 32'({1'b1, AW'(8'h12 + i), 8'hFF}));
        end
        dl_start();
        send_word(0, 16'h0201);
        send_word(2, 16'h0403);
        check("reload_size", 32'(cart_size), 32'd4);
        dl_end(4, 3);
        fill_expect(4);

        // Empty download pads the whole ROM.
        dl_start();
        dl_end(0, 0);
        fill_expect(0);

        // Reset in the middle of a word transfer.
        dl_start();
        wr      = 1'b1;
        io_addr = '0;
        io_data = 16'hBEEF;
        @(posedge clk);
        #2;
        wr = 1'b0;
        check("pre_rst_load", 32'({init_valid, init_data}), 32'({1'b1, 8'hEF}));
        rst = 1'b1;
        #1;
        check_reset("rst_load_now");
        @(negedge clk);
        check_reset("rst_load_next");
        dl = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("after_rst_load", 32'({init_valid, cart_ready}), 32'd0);

        // Reset in the middle of padding.
        dl_start();
        send_word(0, 16'h1234);
        dl_end(2, 1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_fill", 32'({init_valid, init_data}), 32'({1'b1, 8'hFF}));
        rst = 1'b1;
        #1;
        check_reset("rst_fill_now");
        @(negedge clk);
        check_reset("rst_fill_next");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("after_rst_fill");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
